// File: rtl/sram_arb_pkg.sv
// Shared definitions for the SRAM-like bus arbiter: FSM state encoding,
// owner identifiers and transfer-size encodings.
// Imported by sram_arb_grant and sram_bus_arbiter.
package sram_arb_pkg;

  // Transaction state: one outstanding transaction at a time.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,   // no transaction, grant can be made
    ST_ADDR = 2'd1,   // request on the bus, waiting for bus_addr_ok
    ST_DATA = 2'd2    // address accepted, waiting for bus_data_ok
  } arb_state_t;

  // Owner of the current transaction.
  localparam logic OWN_INST = 1'b0;
  localparam logic OWN_DATA = 1'b1;

  // Transfer size encodings carried on *_size.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  // The requester that is not the given owner.
  function automatic logic other_owner(input logic own);
    return (own == OWN_INST) ? OWN_DATA : OWN_INST;
  endfunction

endpackage

// File: rtl/sram_arb_grant.sv
// Combinational grant / tie-break between the fetch and memory-stage requesters.
// Ports: inst_req, data_req in; last_owner in (round-robin build only);
//        grant (any request present), owner (winning requester) out.
// Macro SRAM_ARB_RR_EN: defined -> round-robin ties, undefined -> data wins ties.
module sram_arb_grant
  import sram_arb_pkg::*;
(
  input  logic inst_req,
  input  logic data_req,
`ifdef SRAM_ARB_RR_EN
  input  logic last_owner,
`endif
  output logic grant,
  output logic owner
);

  always_comb begin
    grant = inst_req | data_req;
    owner = OWN_INST;
    if (inst_req && data_req) begin
`ifdef SRAM_ARB_RR_EN
      // Tie: hand the bus to whoever did not win the previous grant.
      owner = other_owner(last_owner);
`else
      // Tie: the memory stage stalls the pipeline harder, so it wins.
      owner = OWN_DATA;
`endif
    end else if (data_req) begin
      owner = OWN_DATA;
    end
  end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Two-master (fetch, memory stage) to one-slave arbiter for the SRAM-like bus,
// one transaction outstanding, req/addr_ok/data_ok sequenced on both sides.
// Ports: cpu_clk, cpu_rst (async, active-high); inst_* and data_* master sides
//        (req/wr/size/addr/wdata in, addr_ok/data_ok/rdata out); bus_* slave
//        side (registered request out, addr_ok/data_ok/rdata in); arb_busy out.
// Macro SRAM_ARB_RR_EN: round-robin tie-break when defined, data-first otherwise.
module sram_bus_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              cpu_clk,
  input  logic              cpu_rst,

  // Instruction-fetch master
  input  logic              inst_req,
  input  logic              inst_wr,
  input  logic [1:0]        inst_size,
  input  logic [ADDR_W-1:0] inst_addr,
  input  logic [DATA_W-1:0] inst_wdata,
  output logic              inst_addr_ok,
  output logic              inst_data_ok,
  output logic [DATA_W-1:0] inst_rdata,

  // Memory-stage data master
  input  logic              data_req,
  input  logic              data_wr,
  input  logic [1:0]        data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wdata,
  output logic              data_addr_ok,
  output logic              data_data_ok,
  output logic [DATA_W-1:0] data_rdata,

  // Slave side toward the AXI bridge
  output logic              bus_req,
  output logic              bus_wr,
  output logic [1:0]        bus_size,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              bus_addr_ok,
  input  logic              bus_data_ok,
  input  logic [DATA_W-1:0] bus_rdata,

  output logic              arb_busy
);

  arb_state_t state;
  logic       owner;
`ifdef SRAM_ARB_RR_EN
  logic       last_owner;
`endif

  logic              grant;
  logic              grant_owner;
  logic              sel_wr;
  logic [1:0]        sel_size;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              addr_ok_any;
  logic              data_ok_any;

  // ---------------------------------------------------------------------------
  // Tie-break
  // ---------------------------------------------------------------------------
  sram_arb_grant u_grant (
    .inst_req   (inst_req),
    .data_req   (data_req),
`ifdef SRAM_ARB_RR_EN
    .last_owner (last_owner),
`endif
    .grant      (grant),
    .owner      (grant_owner)
  );

  // Request fields of whichever master is being granted this cycle.
  always_comb begin
    if (grant_owner == OWN_DATA) begin
      sel_wr    = data_wr;
      sel_size  = data_size;
      sel_addr  = data_addr;
      sel_wdata = data_wdata;
    end else begin
      sel_wr    = inst_wr;
      sel_size  = inst_size;
      sel_addr  = inst_addr;
      sel_wdata = inst_wdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Transaction FSM and bus request registers.
  // The bus fields are only loaded at grant time, so a master that changes its
  // inputs while waiting cannot disturb the request already on the bus.
  // ---------------------------------------------------------------------------
  always_ff @(posedge cpu_clk or posedge cpu_rst) begin
    if (cpu_rst) begin
      state      <= ST_IDLE;
      owner      <= OWN_INST;
`ifdef SRAM_ARB_RR_EN
      // Starting with "data was last" makes the first tie go to fetch.
      last_owner <= OWN_DATA;
`endif
      bus_req    <= 1'b0;
      bus_wr     <= 1'b0;
      bus_size   <= '0;
      bus_addr   <= '0;
      bus_wdata  <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant) begin
            owner      <= grant_owner;
`ifdef SRAM_ARB_RR_EN
            last_owner <= grant_owner;
`endif
            bus_req    <= 1'b1;
            bus_wr     <= sel_wr;
            bus_size   <= sel_size;
            bus_addr   <= sel_addr;
            bus_wdata  <= sel_wdata;
            state      <= ST_ADDR;
          end
        end

        ST_ADDR: begin
          // A data_ok without addr_ok here is meaningless and is dropped.
          if (bus_addr_ok) begin
            bus_req <= 1'b0;
            state   <= bus_data_ok ? ST_IDLE : ST_DATA;
          end
        end

        ST_DATA: begin
          if (bus_data_ok) begin
            state <= ST_IDLE;
          end
        end

        default: begin
          bus_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

  assign arb_busy = (state != ST_IDLE);

  // ---------------------------------------------------------------------------
  // Response routing. Handshakes are combinational so the owner sees the
  // slave's pulse in the same cycle; the non-owner's outputs stay at zero.
  // ---------------------------------------------------------------------------
  assign addr_ok_any = (state == ST_ADDR) && bus_addr_ok;
  // Covers both the normal DATA-state completion and the combined case where
  // the slave answers address and data in one ADDR cycle.
  assign data_ok_any = ((state == ST_DATA) || addr_ok_any) && bus_data_ok;

  assign inst_addr_ok = addr_ok_any && (owner == OWN_INST);
  assign data_addr_ok = addr_ok_any && (owner == OWN_DATA);
  assign inst_data_ok = data_ok_any && (owner == OWN_INST);
  assign data_data_ok = data_ok_any && (owner == OWN_DATA);

  assign inst_rdata = inst_data_ok ? bus_rdata : '0;
  assign data_rdata = data_data_ok ? bus_rdata : '0;

endmodule
